syncslow_arb: RTL
=================

# syncslow_arb

Round-robin scheduler that shares the single transmit side of the two-flop slow synchronizer channel among NREQ requesters in the clk_tx domain. It selects one pending requester, drives that requester's word onto the transmitter's vi/sdata inputs, waits for the transmitter's snt completion, and returns a per-requester done pulse. A watchdog aborts transfers that never complete.

## Interface

- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles spent in WAIT before abort (>= 2)
- DATA_MSB, from def.v, data word MSB (word width DATA_MSB+1)

- clk  in  1  transmitter-domain clock (same clock as transmitter clk_tx)
- reset  in  1  synchronous, active-high reset
- req_v  in  NREQ  requester i has a word pending; held until req_done[i]
- req_data  in  NREQ*(DATA_MSB+1)  word i in bits [i*(DATA_MSB+1) +: DATA_MSB+1]
- snt  in  1  one-cycle completion pulse from transmitter
- vi  out  1  one-cycle start pulse to transmitter
- sdata  out  DATA_MSB+1  word to transmitter, stable from vi until state returns to IDLE
- grant  out  NREQ  one-hot owner of current transfer, 0 in IDLE
- req_done  out  NREQ  one-cycle pulse to the served requester
- err  out  1  one-cycle pulse, coincident with req_done, on timeout
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, SEND, WAIT, DONE. All outputs registered.
- IDLE: if any req_v set, pick winner by round-robin from pointer ptr (search ptr, ptr+1, …, wrap NREQ-1 -> 0); latch its word into sdata, set grant, go SEND. Else stay.
- SEND: vi=1 for exactly this cycle; timeout counter cleared; go WAIT (or DONE if snt sampled this cycle).
- WAIT: counter increments each cycle. snt=1 -> DONE, err stays 0. Counter reaching TIMEOUT-1 without snt -> DONE with err flagged. snt and timeout in same cycle: snt wins, err=0.
- DONE: req_done[winner]=1, err as flagged, for one cycle; ptr <= winner+1 mod NREQ; go IDLE; grant clears on entry to IDLE.
- snt in IDLE or DONE: ignored, no state change.
- req_v of the owner dropping mid-transfer: ignored; transfer completes, req_done still pulses. Other requesters' req_v changes ignored until IDLE.
- Requester whose req_v is still high in IDLE after its req_done is a new request; round robin places it last.
- Timeout counter width $clog2(TIMEOUT); saturates, never wraps.

## Timing

- Reset values: state IDLE, ptr 0, vi 0, sdata 0, grant 0, req_done 0, err 0, busy 0, counter 0.
- reset mid-transfer: all of the above on next edge; transfer abandoned, no req_done, no err.
- req_v sampled high at edge k (IDLE) -> SEND after k: vi=1, grant, sdata valid, busy=1.
- snt high at edge m (SEND/WAIT) -> DONE after m: req_done pulse; IDLE after m+1.
- Minimum transfer: 3 cycles IDLE-exit to IDLE; new grant one cycle later (4-cycle back-to-back throughput).
- Timeout: req_done/err pulse TIMEOUT+1 cycles after vi.

## Structure

- DATA_MSB stays in the shared def.v include; add state encodings (IDLE=0, SEND=1, WAIT=2, DONE=3) there as localparams/defines for reuse by the matching receive-side scheduler.
- One natural sub-module: syncslow_rr_pick (combinational round-robin one-hot picker: req vector + ptr -> one-hot grant + index).
- Top-level integration: syncslow_arb drives syncslow's vi/sdata, takes its snt.

## Test plan

- Single request: req_v=4'b0010, data1=0xA5, snt 5 cycles after vi -> one vi pulse, sdata=0xA5, grant=4'b0010, req_done=4'b0010 one cycle after snt, err=0.
- All pending: req_v=4'b1111 held, each completes on snt -> grant order 0,1,2,3,0; ptr wraps 3->0.
- Timeout: TIMEOUT=8, no snt -> req_done and err pulse together 9 cycles after vi; next requester served.
- snt and timeout coincident -> err=0; stray snt in IDLE -> no state change, no req_done.
- Owner drops req_v during WAIT -> req_done still pulses; reset asserted in WAIT -> all outputs 0 next cycle, ptr=0, no req_done.

Source files
------------

// File: rtl/syncslow_arb_pkg.sv
// Shared definitions for the slow-synchronizer schedulers: word width and state encodings
// (the receive-side scheduler reuses the same encodings).
package syncslow_arb_pkg;

  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_W   = DATA_MSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/syncslow_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module syncslow_rr_pick
  import syncslow_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [IDX_W-1:0] cand;

  // Scan offsets 0..NREQ-1 from ptr; the first hit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = ((32'(ptr) + off) >= NREQ) ? IDX_W'(32'(ptr) + off - NREQ)
                                        : IDX_W'(32'(ptr) + off);
      if (!any_c && req[cand]) begin
        any_c         = 1'b1;
        idx_c         = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syncslow_arb.sv
// Round-robin scheduler sharing the slow-synchronizer transmitter among NREQ requesters,
// with a watchdog that aborts transfers whose snt never arrives.
module syncslow_arb
  import syncslow_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_v,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   snt,
  output logic                   vi,
  output logic [DATA_W-1:0]      sdata,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        req_done,
  output logic                   err,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   winner, winner_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               vi_nxt, err_nxt, busy_nxt;
  logic [DATA_W-1:0]  sdata_nxt;
  logic [NREQ-1:0]    grant_nxt, req_done_nxt;

  logic [NREQ-1:0]    pick_grant_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;

  syncslow_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_v),
    .ptr     (ptr),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      winner   <= '0;
      cnt      <= '0;
      vi       <= 1'b0;
      sdata    <= '0;
      grant    <= '0;
      req_done <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      winner   <= winner_nxt;
      cnt      <= cnt_nxt;
      vi       <= vi_nxt;
      sdata    <= sdata_nxt;
      grant    <= grant_nxt;
      req_done <= req_done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    winner_nxt   = winner;
    cnt_nxt      = cnt;
    vi_nxt       = 1'b0;
    sdata_nxt    = sdata;
    grant_nxt    = grant;
    req_done_nxt = '0;
    err_nxt      = 1'b0;
    busy_nxt     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (pick_any_c) begin
          state_nxt  = ST_SEND;
          winner_nxt = pick_idx_c;
          grant_nxt  = pick_grant_c;
          vi_nxt     = 1'b1;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx_c == IDX_W'(i)) sdata_nxt = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      ST_SEND: begin
        cnt_nxt = '0;
        if (snt) begin
          state_nxt    = ST_DONE;
          req_done_nxt = grant;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // snt takes priority over an expiring watchdog.
        if (snt) begin
          state_nxt    = ST_DONE;
          req_done_nxt = grant;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = ST_DONE;
          req_done_nxt = grant;
          err_nxt      = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        ptr_nxt   = (winner == IDX_LAST) ? '0 : winner + 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
